pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the 5-stage core: generates per-stage stall and flush controls, including the `id_exe_flush` consumed by the ID/EXE pipeline register. It handles three conditions:
- load-use hazards, by inserting a bubble;
- taken jumps/branches resolved in EXE, by flushing the younger stages and redirecting the PC;
- multi-cycle MDU operations, by freezing the front of the pipe in a wait state with a watchdog.

It also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- `MDU_TIMEOUT`, default 64: maximum number of MDU_WAIT cycles before the watchdog aborts.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk_i`, in, 1: sole clock, rising edge.
- `rst_i`, in, 1: reset, synchronous, active-low.
- `id_rs1_raddr_i`, `id_rs2_raddr_i`, in, 5 each: source register addresses of the instruction in ID.
- `id_rs1_re_i`, `id_rs2_re_i`, in, 1 each: the ID instruction reads rs1 / rs2.
- `exe_reg_waddr_i`, in, 5: destination register of the instruction in EXE.
- `exe_reg_we_i`, in, 1: the EXE instruction writes a register.
- `exe_is_load_i`, in, 1: the EXE instruction is a load.
- `exe_jump_i`, in, 1: the EXE instruction is a taken jump/branch.
- `exe_jump_addr_i`, in, 32: redirect target.
- `mdu_start_i`, in, 1: EXE issues a multi-cycle MDU op this cycle.
- `mdu_done_i`, in, 1: the MDU result is valid this cycle.
- `pc_stall_o`, `if_id_stall_o`, `id_exe_stall_o`, out, 1 each: hold the corresponding register.
- `if_id_flush_o`, `id_exe_flush_o`, out, 1 each: load NOP into the corresponding register.
- `exe_mem_bubble_o`, out, 1: EXE/MEM captures a NOP.
- `pc_redirect_o`, out, 1: PC loads `pc_redirect_addr_o`.
- `pc_redirect_addr_o`, out, 32: redirect address.
- `mdu_err_o`, out, 1: sticky watchdog error flag.
- `stall_cnt_o`, `flush_cnt_o`, out, `CNT_W` each: performance counters.

## Operation
State machine (state, watchdog counter, error flag and performance counters are registered):
- **IDLE**
  - If `mdu_start_i` is high and `mdu_done_i` is low, go to MDU_WAIT and clear the watchdog.
  - If `mdu_start_i` and `mdu_done_i` are high together (single-cycle completion), stay in IDLE.
- **MDU_WAIT**
  - Assert `pc_stall_o`, `if_id_stall_o`, `id_exe_stall_o` and `exe_mem_bubble_o`.
  - The watchdog increments every cycle.
  - On `mdu_done_i`: all four outputs go low in that same cycle, so the result advances; next state is IDLE.
  - If the watchdog reaches `MDU_TIMEOUT-1` with no done: set `mdu_err_o`, deassert the stalls that cycle, next state is IDLE.

Decode priority in IDLE (combinational from the inputs and state), highest first:
1. **Jump.** `exe_jump_i` asserts `pc_redirect_o`, `if_id_flush_o` and `id_exe_flush_o`; `pc_redirect_addr_o` equals `exe_jump_addr_i`. The load-use stall is suppressed because the ID instruction is discarded.
2. **Load-use.** A hazard exists when all of the following hold:
   - `exe_is_load_i` and `exe_reg_we_i` are high;
   - `exe_reg_waddr_i` is not 0;
   - the address matches `id_rs1_raddr_i` with `id_rs1_re_i` high, or `id_rs2_raddr_i` with `id_rs2_re_i` high.

   Response: assert `pc_stall_o` and `if_id_stall_o`, plus `id_exe_flush_o` (a bubble). It lasts exactly one cycle; the load then moves to MEM and forwarding covers the dependency.
3. **Otherwise** all control outputs are low.

Other rules:
- In MDU_WAIT, `exe_jump_i` and the load-use terms are ignored because EXE is frozen.
- `mdu_start_i` is only honoured in IDLE.
- When a stall and a flush target the same register, flush wins. This only occurs for `id_exe` on load-use, where the stall is not asserted.
- `stall_cnt_o` increments in any cycle with `pc_stall_o` high.
- `flush_cnt_o` increments in any cycle with `pc_redirect_o` high.
- Both counters saturate at all-ones and never wrap.
- `mdu_err_o` clears only on reset.

## Timing
- All control outputs are combinational with zero latency, so they are valid in time for the same rising edge at which the pipeline registers sample.
- On reset (`rst_i` low at an edge):
  - state goes to IDLE; watchdog, `mdu_err_o`, `stall_cnt_o` and `flush_cnt_o` go to 0;
  - while `rst_i` is low, all stall, flush, bubble and redirect outputs are forced to 0, and `pc_redirect_addr_o` is 0;
  - reset in the middle of MDU_WAIT abandons the wait; the first post-reset cycle is IDLE.
- MDU_WAIT lasts from the cycle after the start through the done cycle inclusive, at most `MDU_TIMEOUT` cycles.
- Watchdog and counter arithmetic is unsigned and saturating; the watchdog is `$clog2(MDU_TIMEOUT)+1` bits.

## Structure
- Shared defines header holds:
  - state encodings `CtrlIdle` and `CtrlMduWait`;
  - `FlushEnable`, `StallEnable`, `ZeroReg`, `ZeroWord`;
  - `RstEnable`, defined as 1'b0.
- One sub-module, `sat_counter` (parameter `W`; inputs `inc` and synchronous active-low clear), instantiated twice for the performance counters.
- Hazard decode stays inline.

## Test plan
- **Reset:** hold `rst_i` low for 3 cycles while `exe_jump_i` and `mdu_start_i` are high → all outputs 0, counters 0; on release, state is IDLE.
- **Load-use:** `exe_is_load_i`=1, `exe_reg_we_i`=1, `exe_reg_waddr_i`=5, `id_rs2_raddr_i`=5, `id_rs2_re_i`=1 → for exactly one cycle `pc_stall_o`=`if_id_stall_o`=`id_exe_flush_o`=1 and `id_exe_stall_o`=0; `stall_cnt_o` becomes 1. Repeat with waddr 0 or `id_rs2_re_i`=0 → no stall.
- **Jump vs load-use:** both conditions true, `exe_jump_addr_i`=0x80 → `pc_redirect_o`=1, `pc_redirect_addr_o`=0x80, both flushes high, `pc_stall_o`=0; `flush_cnt_o` increments by 1.
- **MDU wait:** `mdu_start_i` pulse, with `mdu_done_i` arriving 5 cycles later → the three stalls plus `exe_mem_bubble_o` are high for 4 cycles and low in the done cycle; `stall_cnt_o`=4. A start coincident with done → no stall.
- **Watchdog:** `MDU_TIMEOUT`=8, start with no done → the stall is released on the 8th MDU_WAIT cycle, `mdu_err_o`=1 sticky, IDLE follows; a jump during the wait is ignored.
- **Reset mid-wait plus saturation:** assert reset in the 3rd MDU_WAIT cycle → IDLE with outputs 0. With `CNT_W`=3, 9 stall cycles → `stall_cnt_o` holds at 7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    CtrlIdle    = 1'b0,
    CtrlMduWait = 1'b1
  } ctrl_state_e;

  localparam logic      FlushEnable = 1'b1;
  localparam logic      StallEnable = 1'b1;
  localparam reg_addr_t ZeroReg     = 5'd0;
  localparam word_t     ZeroWord    = 32'h0000_0000;
  localparam logic      RstEnable   = 1'b0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stall/flush/redirect outputs between the pipeline and its control unit.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  reg_addr_t        id_rs1_raddr_i;
  reg_addr_t        id_rs2_raddr_i;
  logic             id_rs1_re_i;
  logic             id_rs2_re_i;
  reg_addr_t        exe_reg_waddr_i;
  logic             exe_reg_we_i;
  logic             exe_is_load_i;
  logic             exe_jump_i;
  word_t            exe_jump_addr_i;
  logic             mdu_start_i;
  logic             mdu_done_i;

  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             id_exe_stall_o;
  logic             if_id_flush_o;
  logic             id_exe_flush_o;
  logic             exe_mem_bubble_o;
  logic             pc_redirect_o;
  word_t            pc_redirect_addr_o;
  logic             mdu_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i, id_rs2_re_i,
           exe_reg_waddr_i, exe_reg_we_i, exe_is_load_i, exe_jump_i,
           exe_jump_addr_i, mdu_start_i, mdu_done_i,
    input  pc_stall_o, if_id_stall_o, id_exe_stall_o, if_id_flush_o,
           id_exe_flush_o, exe_mem_bubble_o, pc_redirect_o,
           pc_redirect_addr_o, mdu_err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_raddr_i, id_rs2_raddr_i, id_rs1_re_i, id_rs2_re_i,
           exe_reg_waddr_i, exe_reg_we_i, exe_is_load_i, exe_jump_i,
           exe_jump_addr_i, mdu_start_i, mdu_done_i,
    output pc_stall_o, if_id_stall_o, id_exe_stall_o, if_id_flush_o,
           id_exe_flush_o, exe_mem_bubble_o, pc_redirect_o,
           pc_redirect_addr_o, mdu_err_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: load-use bubbles, EXE jump flush/redirect, MDU freeze with watchdog,
// and saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_ctrl_if.slave bus
);

  localparam int              WD_W    = $clog2(MDU_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

  ctrl_state_e     state_reg, state_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            err_reg, err_next;

  logic  load_use;
  logic  pc_stall, if_id_stall, id_exe_stall;
  logic  if_id_flush, id_exe_flush, exe_mem_bubble;
  logic  pc_redirect;
  word_t redirect_addr;

  assign load_use = bus.exe_is_load_i && bus.exe_reg_we_i &&
                    (bus.exe_reg_waddr_i != ZeroReg) &&
                    ((bus.id_rs1_re_i && (bus.id_rs1_raddr_i == bus.exe_reg_waddr_i)) ||
                     (bus.id_rs2_re_i && (bus.id_rs2_raddr_i == bus.exe_reg_waddr_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      state_reg <= CtrlIdle;
      wd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wd_reg    <= wd_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wd_next        = wd_reg;
    err_next       = err_reg;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    id_exe_stall   = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_flush   = 1'b0;
    exe_mem_bubble = 1'b0;
    pc_redirect    = 1'b0;
    redirect_addr  = ZeroWord;

    // Under reset every control is held inactive; the registers clear in the always_ff.
    if (rst_i != RstEnable) begin
      unique case (state_reg)
        CtrlIdle: begin
          if (bus.exe_jump_i) begin
            pc_redirect   = 1'b1;
            redirect_addr = bus.exe_jump_addr_i;
            if_id_flush   = FlushEnable;
            id_exe_flush  = FlushEnable;
          end else if (load_use) begin
            pc_stall     = StallEnable;
            if_id_stall  = StallEnable;
            id_exe_flush = FlushEnable;
          end
          if (bus.mdu_start_i && !bus.mdu_done_i) begin
            state_next = CtrlMduWait;
            wd_next    = '0;
          end
        end
        CtrlMduWait: begin
          // EXE is frozen here, so jump and load-use terms are deliberately not decoded.
          if (bus.mdu_done_i) begin
            state_next = CtrlIdle;
          end else if (wd_reg == WD_LAST) begin
            err_next   = 1'b1;
            state_next = CtrlIdle;
          end else begin
            pc_stall       = StallEnable;
            if_id_stall    = StallEnable;
            id_exe_stall   = StallEnable;
            exe_mem_bubble = 1'b1;
          end
          if (wd_reg != '1) begin
            wd_next = wd_reg + WD_W'(1);
          end
        end
        default: state_next = CtrlIdle;
      endcase
    end
  end

  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {pc_redirect, pc_stall};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk_i),
      .clr_n (rst_i),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign bus.pc_stall_o         = pc_stall;
  assign bus.if_id_stall_o      = if_id_stall;
  assign bus.id_exe_stall_o     = id_exe_stall;
  assign bus.if_id_flush_o      = if_id_flush;
  assign bus.id_exe_flush_o     = id_exe_flush;
  assign bus.exe_mem_bubble_o   = exe_mem_bubble;
  assign bus.pc_redirect_o      = pc_redirect;
  assign bus.pc_redirect_addr_o = redirect_addr;
  assign bus.mdu_err_o          = err_reg;
  assign bus.stall_cnt_o        = cnt_val[0];
  assign bus.flush_cnt_o        = cnt_val[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and random stimulus for pipe_ctrl, checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO   = 8;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_k is the 1-based index of the current MDU wait cycle.
  bit m_wait = 1'b0;
  int m_k    = 0;
  bit m_err  = 1'b0;
  int m_sc   = 0;
  int m_fc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.id_rs1_raddr_i  = '0;
    bus.id_rs2_raddr_i  = '0;
    bus.id_rs1_re_i     = 1'b0;
    bus.id_rs2_re_i     = 1'b0;
    bus.exe_reg_waddr_i = '0;
    bus.exe_reg_we_i    = 1'b0;
    bus.exe_is_load_i   = 1'b0;
    bus.exe_jump_i      = 1'b0;
    bus.exe_jump_addr_i = '0;
    bus.mdu_start_i     = 1'b0;
    bus.mdu_done_i      = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs2, input logic re2);
    bus.exe_is_load_i   = 1'b1;
    bus.exe_reg_we_i    = 1'b1;
    bus.exe_reg_waddr_i = rd;
    bus.id_rs2_raddr_i  = rs2;
    bus.id_rs2_re_i     = re2;
  endtask

  // One clock: check every output mid-cycle against the model, then advance the model.
  task automatic cycle(input string tag);
    bit    e_pcs, e_ifs, e_ids, e_iff, e_idf, e_bub, e_red, lu, hold;
    logic [31:0] e_addr;
    @(negedge clk);
    {e_pcs, e_ifs, e_ids, e_iff, e_idf, e_bub, e_red} = '0;
    e_addr = 32'h0;
    lu = bus.exe_is_load_i && bus.exe_reg_we_i && (bus.exe_reg_waddr_i != 5'd0) &&
         ((bus.id_rs1_re_i && bus.id_rs1_raddr_i == bus.exe_reg_waddr_i) ||
          (bus.id_rs2_re_i && bus.id_rs2_raddr_i == bus.exe_reg_waddr_i));
    if (rst) begin
      if (m_wait) begin
        hold  = !bus.mdu_done_i && (m_k < TO);
        e_pcs = hold; e_ifs = hold; e_ids = hold; e_bub = hold;
      end else if (bus.exe_jump_i) begin
        e_red = 1'b1; e_iff = 1'b1; e_idf = 1'b1; e_addr = bus.exe_jump_addr_i;
      end else if (lu) begin
        e_pcs = 1'b1; e_ifs = 1'b1; e_idf = 1'b1;
      end
    end
    $display("%0t %s rst=%0b pcs=%0b ifs=%0b ids=%0b iff=%0b idf=%0b bub=%0b red=%0b addr=%0h err=%0b sc=%0d fc=%0d",
             $time, tag, rst, bus.pc_stall_o, bus.if_id_stall_o, bus.id_exe_stall_o,
             bus.if_id_flush_o, bus.id_exe_flush_o, bus.exe_mem_bubble_o, bus.pc_redirect_o,
             bus.pc_redirect_addr_o, bus.mdu_err_o, bus.stall_cnt_o, bus.flush_cnt_o);
    chk({tag, ".pc_stall"},    32'(bus.pc_stall_o),       32'(e_pcs));
    chk({tag, ".if_id_stall"}, 32'(bus.if_id_stall_o),    32'(e_ifs));
    chk({tag, ".id_exe_stall"},32'(bus.id_exe_stall_o),   32'(e_ids));
    chk({tag, ".if_id_flush"}, 32'(bus.if_id_flush_o),    32'(e_iff));
    chk({tag, ".id_exe_flush"},32'(bus.id_exe_flush_o),   32'(e_idf));
    chk({tag, ".bubble"},      32'(bus.exe_mem_bubble_o), 32'(e_bub));
    chk({tag, ".redirect"},    32'(bus.pc_redirect_o),    32'(e_red));
    chk({tag, ".redir_addr"},  bus.pc_redirect_addr_o,    e_addr);
    chk({tag, ".mdu_err"},     32'(bus.mdu_err_o),        32'(m_err));
    chk({tag, ".stall_cnt"},   32'(bus.stall_cnt_o),      32'(m_sc));
    chk({tag, ".flush_cnt"},   32'(bus.flush_cnt_o),      32'(m_fc));
    if (!rst) begin
      m_wait = 1'b0; m_k = 0; m_err = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (e_pcs && m_sc < CMAX) m_sc++;
      if (e_red && m_fc < CMAX) m_fc++;
      if (m_wait) begin
        if (!bus.mdu_done_i && m_k == TO) m_err = 1'b1;
        if (bus.mdu_done_i || m_k == TO) m_wait = 1'b0;
        else m_k++;
      end else if (bus.mdu_start_i && !bus.mdu_done_i) begin
        m_wait = 1'b1;
        m_k    = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle("reset");
    rst = 1'b1;
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with jump and start active
    bus.exe_jump_i = 1'b1; bus.mdu_start_i = 1'b1; bus.exe_jump_addr_i = 32'h80;
    for (int i = 0; i < 3; i++) cycle("rst_hold");
    clear_in();
    rst = 1'b1;
    cycle("idle");

    // Load-use on rs2
    set_load_use(5'd5, 5'd5, 1'b1);
    cycle("lu");
    clear_in();
    cycle("lu_after");
    chk("lu_stall_cnt", 32'(bus.stall_cnt_o), 32'd1);
    set_load_use(5'd0, 5'd0, 1'b1);
    cycle("lu_x0");
    set_load_use(5'd5, 5'd5, 1'b0);
    cycle("lu_nore");
    clear_in();
    bus.exe_is_load_i = 1'b1; bus.exe_reg_we_i = 1'b1; bus.exe_reg_waddr_i = 5'd7;
    bus.id_rs1_raddr_i = 5'd7; bus.id_rs1_re_i = 1'b1;
    cycle("lu_rs1");

    // Jump beats load-use
    set_load_use(5'd5, 5'd5, 1'b1);
    bus.exe_jump_i = 1'b1; bus.exe_jump_addr_i = 32'h80;
    cycle("jmp_lu");
    clear_in();
    cycle("jmp_after");
    chk("jmp_flush_cnt", 32'(bus.flush_cnt_o), 32'd1);

    // MDU wait with done five cycles after start
    do_reset();
    bus.mdu_start_i = 1'b1;
    cycle("mdu_start");
    bus.mdu_start_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle("mdu_wait");
    bus.mdu_done_i = 1'b1;
    cycle("mdu_done");
    clear_in();
    cycle("mdu_after");
    chk("mdu_stall_cnt", 32'(bus.stall_cnt_o), 32'd4);
    bus.mdu_start_i = 1'b1; bus.mdu_done_i = 1'b1;
    cycle("mdu_single");
    clear_in();
    cycle("mdu_single_after");
    chk("mdu_single_cnt", 32'(bus.stall_cnt_o), 32'd4);

    // Watchdog expiry, jump during wait ignored
    do_reset();
    bus.mdu_start_i = 1'b1;
    cycle("wd_start");
    bus.mdu_start_i = 1'b0;
    bus.exe_jump_i = 1'b1; bus.exe_jump_addr_i = 32'h44;
    for (int i = 0; i < TO; i++) cycle("wd_wait");
    clear_in();
    cycle("wd_idle");
    cycle("wd_idle2");
    chk("wd_err_sticky", 32'(bus.mdu_err_o), 32'd1);
    chk("wd_no_redirect", 32'(bus.flush_cnt_o), 32'd0);

    // Reset in the third wait cycle
    bus.mdu_start_i = 1'b1;
    cycle("rmw_start");
    bus.mdu_start_i = 1'b0;
    cycle("rmw_wait1");
    cycle("rmw_wait2");
    rst = 1'b0;
    cycle("rmw_reset");
    rst = 1'b1;
    cycle("rmw_idle");
    chk("rmw_err_cleared", 32'(bus.mdu_err_o), 32'd0);

    // Stall counter saturation
    do_reset();
    set_load_use(5'd3, 5'd3, 1'b1);
    for (int i = 0; i < 9; i++) cycle("sat");
    clear_in();
    cycle("sat_after");
    chk("sat_stall_cnt", 32'(bus.stall_cnt_o), 32'd7);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst                 = ($urandom_range(0, 63) != 0);
      bus.id_rs1_raddr_i  = 5'($urandom_range(0, 3));
      bus.id_rs2_raddr_i  = 5'($urandom_range(0, 3));
      bus.id_rs1_re_i     = 1'($urandom_range(0, 1));
      bus.id_rs2_re_i     = 1'($urandom_range(0, 1));
      bus.exe_reg_waddr_i = 5'($urandom_range(0, 3));
      bus.exe_reg_we_i    = 1'($urandom_range(0, 1));
      bus.exe_is_load_i   = 1'($urandom_range(0, 1));
      bus.exe_jump_i      = ($urandom_range(0, 7) == 0);
      bus.exe_jump_addr_i = $urandom;
      bus.mdu_start_i     = ($urandom_range(0, 5) == 0);
      bus.mdu_done_i      = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
